// File: rtl/multi_delay_timer.sv
// rtl/multi_delay_timer.sv - multi-channel programmable delay timer sharing one base-tick prescaler
module multi_delay_timer #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int TICK_PERIOD = 500000,
    parameter int TICK_W      = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] delay,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       done_pulse,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*CNT_W-1:0] remaining
);

    localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_PERIOD - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [TICK_W-1:0] presc;
    logic              tick;

    // Free-running shared prescaler; only reset realigns it, so start-to-first-tick jitters.
    assign tick = enable && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (enable) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    assign done = ~busy;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] rem;
        logic [CNT_W-1:0] lat_delay;
        logic             lat_per;
        logic             pulse;
        logic [CNT_W-1:0] din;

        assign din = delay[g*CNT_W +: CNT_W];

        // Priority abort > start > tick; a zero-delay start expires immediately.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= IDLE;
                rem       <= '0;
                lat_delay <= '0;
                lat_per   <= 1'b0;
                pulse     <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (abort[g]) begin
                    state <= IDLE;
                    rem   <= '0;
                end else if (start[g]) begin
                    if (din != '0) begin
                        lat_delay <= din;
                        lat_per   <= periodic[g];
                        rem       <= din;
                        state     <= RUN;
                    end else begin
                        rem   <= '0;
                        state <= IDLE;
                        pulse <= 1'b1;
                    end
                end else if (state == RUN && tick) begin
                    if (rem > CNT_W'(1)) begin
                        rem <= rem - CNT_W'(1);
                    end else begin
                        pulse <= 1'b1;
                        if (lat_per) begin
                            rem <= lat_delay;
                        end else begin
                            rem   <= '0;
                            state <= IDLE;
                        end
                    end
                end
            end
        end

        assign busy[g]                      = (state == RUN);
        assign done_pulse[g]                = pulse;
        assign remaining[g*CNT_W +: CNT_W]  = rem;
    end

endmodule

// File: tb/tb_multi_delay_timer.sv
// tb/tb_multi_delay_timer.sv - scoreboard bench for multi_delay_timer against a cycle-count reference model
module tb_multi_delay_timer;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int TP  = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b0;
    logic [NCH-1:0]  start = '0, abort = '0, periodic = '0;
    logic [NCH*CW-1:0] delay = '0;
    logic [NCH-1:0]  done, done_pulse, busy;
    logic [NCH*CW-1:0] remaining;

    multi_delay_timer #(.NUM_CH(NCH), .CNT_W(CW), .TICK_PERIOD(TP), .TICK_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .abort(abort),
        .periodic(periodic), .delay(delay), .done(done), .done_pulse(done_pulse),
        .busy(busy), .remaining(remaining)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0]    pulse;
        logic [NCH-1:0]    busy;
        logic [NCH*CW-1:0] rem;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: counts enabled clocks since reset; a tick is every TP-th enabled clock.
    int ecount = 0;
    int mrem[NCH];
    bit mrun[NCH];
    bit mper[NCH];
    int mdly[NCH];
    logic rn_next = 1'b1;

    function automatic bit tick_next(input bit en);
        return en && (ecount % TP == TP - 1);
    endfunction

    task automatic model_reset();
        ecount = 0;
        for (int c = 0; c < NCH; c++) begin
            mrem[c] = 0; mrun[c] = 0; mper[c] = 0; mdly[c] = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic step(input bit en, input logic [1:0] st, input logic [1:0] ab,
                        input logic [1:0] per, input int d0, input int d1);
        exp_t e;
        bit   tk;
        int   din;
        @(negedge clk);
        reset_n  = rn_next;
        enable   = en;
        start    = st;
        abort    = ab;
        periodic = per;
        delay    = {CW'(d1), CW'(d0)};
        e = '0;
        if (!rn_next) begin
            model_reset();
        end else begin
            tk = tick_next(en);
            for (int c = 0; c < NCH; c++) begin
                din = (c == 0) ? d0 : d1;
                if (ab[c]) begin
                    mrun[c] = 0; mrem[c] = 0;
                end else if (st[c]) begin
                    if (din != 0) begin
                        mdly[c] = din; mper[c] = per[c]; mrem[c] = din; mrun[c] = 1;
                    end else begin
                        mrun[c] = 0; mrem[c] = 0; e.pulse[c] = 1'b1;
                    end
                end else if (mrun[c] && tk) begin
                    if (mrem[c] > 1) begin
                        mrem[c]--;
                    end else begin
                        e.pulse[c] = 1'b1;
                        if (mper[c]) mrem[c] = mdly[c];
                        else begin mrem[c] = 0; mrun[c] = 0; end
                    end
                end
            end
            if (en) ecount++;
        end
        for (int c = 0; c < NCH; c++) begin
            e.busy[c] = mrun[c];
            e.rem[c*CW +: CW] = CW'(mrem[c]);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 2'b00, 2'b00, 2'b00, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a state, compared against the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (done_pulse !== e.pulse || busy !== e.busy || done !== ~e.busy
                    || remaining !== e.rem) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t: got pulse=%b busy=%b done=%b rem=%h expected pulse=%b busy=%b done=%b rem=%h",
                             $time, done_pulse, busy, done, remaining, e.pulse, e.busy, ~e.busy, e.rem);
                end
            end
        end
    end

    initial begin
        int guard;
        model_reset();
        #2;
        check("reset_done", 32'(done), 32'(2'b11));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pulse", 32'(done_pulse), 32'd0);
        check("reset_rem", 32'(remaining), 32'd0);

        rn_next = 1'b1;
        idle(9, 1'b1);

        // One-shot delay 3 on ch0
        step(1'b1, 2'b01, 2'b00, 2'b00, 3, 0);
        idle(14, 1'b1);

        // Periodic delay 2 on ch1, then abort
        step(1'b1, 2'b10, 2'b00, 2'b10, 0, 2);
        idle(30, 1'b1);
        step(1'b1, 2'b00, 2'b10, 2'b00, 0, 0);
        idle(12, 1'b1);

        // start+abort together, then zero-delay start
        step(1'b1, 2'b01, 2'b01, 2'b00, 4, 0);
        idle(3, 1'b1);
        step(1'b1, 2'b01, 2'b00, 2'b01, 0, 0);
        idle(3, 1'b1);

        // Freeze with remaining=1, then release
        step(1'b1, 2'b01, 2'b00, 2'b00, 2, 0);
        guard = 0;
        while (mrem[0] != 1 && guard < 40) begin idle(1, 1'b1); guard++; end
        check("reach_rem1", 32'(mrem[0] == 1), 32'd1);
        idle(20, 1'b0);
        idle(8, 1'b1);

        // Restart with delay 5 exactly in the tick cycle at remaining=1
        step(1'b1, 2'b01, 2'b00, 2'b00, 3, 0);
        guard = 0;
        while (!(mrem[0] == 1 && tick_next(1'b1)) && guard < 60) begin idle(1, 1'b1); guard++; end
        check("reach_tick_rem1", 32'(guard < 60), 32'd1);
        step(1'b1, 2'b01, 2'b00, 2'b00, 5, 0);
        idle(3, 1'b1);
        step(1'b1, 2'b00, 2'b01, 2'b00, 0, 0);

        // Asynchronous reset mid-cycle with both channels running
        step(1'b1, 2'b11, 2'b00, 2'b11, 7, 5);
        idle(6, 1'b1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        rn_next = 1'b0;
        model_reset();
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'(2'b11));
        check("async_rem", 32'(remaining), 32'd0);
        check("async_pulse", 32'(done_pulse), 32'd0);
        idle(2, 1'b1);
        rn_next = 1'b1;
        idle(12, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] st, ab, per;
            int d0, d1;
            st  = 2'($urandom_range(0, 15) == 0) | (2'($urandom_range(0, 15) == 0) << 1);
            ab  = 2'($urandom_range(0, 40) == 0) | (2'($urandom_range(0, 40) == 0) << 1);
            per = 2'($urandom_range(0, 3));
            d0  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            d1  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            step($urandom_range(0, 9) != 0, st, ab, per, d0, d1);
        end

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_delay_timer.md
Name: multi_delay_timer

Overview:
Multi-channel programmable delay timer for the application-specific processor. It generalises the single 1/100 s delay counter to NUM_CH independent channels. All channels share one prescaler that generates a base tick every TICK_PERIOD clocks. Each channel supports one-shot or periodic (auto-reload) mode, abort, and a one-cycle expiry pulse, so the sequencer can time several operations at once.

Parameters:
NUM_CH, 4, number of independent delay channels
CNT_W, 8, width of each channel's delay count (max 2^CNT_W-1 ticks)
TICK_PERIOD, 500000, clocks per base tick (1/100 s at 50 MHz); must be >= 2
TICK_W, 20, prescaler width; 2^TICK_W must be >= TICK_PERIOD

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  global run enable; low freezes the prescaler (channels hold their state)
start  in  NUM_CH  per-channel load/start strobe
abort  in  NUM_CH  per-channel cancel strobe
periodic  in  NUM_CH  per-channel mode, sampled at start: 1 = auto-reload, 0 = one-shot
delay  in  NUM_CH*CNT_W  per-channel delay in ticks; channel i uses bits [i*CNT_W +: CNT_W], sampled at start
done  out  NUM_CH  level, 1 when the channel is idle (equal to ~busy)
done_pulse  out  NUM_CH  one-cycle strobe on expiry
busy  out  NUM_CH  channel is counting
remaining  out  NUM_CH*CNT_W  current down-count per channel

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n. All state is registered.
- Reset values: prescaler = 0, tick = 0, every remaining = 0, busy = 0, done = all 1s, done_pulse = 0, latched delay/mode = 0.
- Prescaler: counts 0..TICK_PERIOD-1 while enable = 1, then wraps to 0. The internal tick is high for exactly the one cycle in which the count is TICK_PERIOD-1 and enable = 1. The period is exactly TICK_PERIOD clocks; the old design's off-by-one (PERIOD+1) is removed.
- Prescaler clearing: only reset clears it. start does not clear it.
- Tick timing: the first tick after a start arrives 1..TICK_PERIOD clocks later, so a delay of N ticks spans (N-1)*TICK_PERIOD+1 .. N*TICK_PERIOD clocks. This jitter is accepted.
- Per-channel FSM, states IDLE and RUN. Priority within a channel, highest first: abort > start > tick.
  - abort (any state): next state IDLE, remaining = 0, no done_pulse. A start in the same cycle is ignored.
  - start with delay != 0: latch delay and periodic, set remaining = delay, next state RUN. This applies in both IDLE and RUN; in RUN it restarts the channel. A tick in the same cycle is ignored for that channel, and no pulse is produced.
  - start with delay = 0: next state IDLE, remaining = 0, done_pulse = 1 on the next cycle. This holds regardless of periodic.
  - RUN, tick, remaining > 1: remaining decrements by 1.
  - RUN, tick, remaining = 1, one-shot: remaining = 0, next state IDLE, done_pulse = 1 for one cycle.
  - RUN, tick, remaining = 1, periodic: remaining reloads the latched delay, the channel stays in RUN, done_pulse = 1 for one cycle. The pulse repeats every latched-delay ticks until abort or a new start.
  - IDLE, tick: no effect.
- Output timing: done_pulse and busy are registered and change in the cycle after the causing edge. done = ~busy.
- Independence: channels are fully independent apart from the shared tick. Simultaneous expiries on several channels raise several done_pulse bits in the same cycle.
- enable low: tick is suppressed, remaining holds, and start/abort remain functional.
- Arithmetic: remaining never underflows. The decrement occurs only when remaining >= 2; the value 1 is handled by the expiry rules above.
- Reset mid-operation: all channels return immediately (asynchronously) to the reset values. No pulse is generated.

Test Plan:
1. TICK_PERIOD=4, NUM_CH=2. After reset, hold enable=1 and count cycles between ticks -> tick every 4 clocks. Before any start: done=2'b11, busy=0, remaining=0.
2. ch0 start, delay=3, one-shot -> busy[0]=1, remaining 3->2->1->0 on successive ticks. A single done_pulse[0] coincides with busy falling. Start-to-pulse time is within 9..12 clocks.
3. ch1 start, delay=2, periodic -> done_pulse[1] every 8 clocks, at least 3 times; remaining reloads to 2. Assert abort[1] -> busy[1]=0 next cycle, remaining=0, no further pulses.
4. Drive start and abort on ch0 in the same cycle -> ch0 stays idle. start with delay=0 -> done_pulse[0] the next cycle, busy stays 0.
5. ch0 running with remaining=1: hold enable=0 for 20 clocks -> no pulse, remaining holds at 1. Raise enable -> pulse at the next tick. Restart with delay=5 when remaining=1, in the tick cycle -> remaining=5, no pulse.
6. Deassert reset_n asynchronously, mid-cycle, while both channels run -> outputs reach reset values before the next clk edge. No done_pulse after release until a new start.
